line_encoder: RTL and testbench

LINE_ENCODER -- requirements
Module: line_encoder

---
 rtl/line_encoder.sv | 76 +++++++
 tb/tb_line_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_encoder.sv
// rtl/line_encoder.sv - serialises the set bits of a 16-line vector into 4-bit addresses
// Define LINE_ENCODER_HIGH_FIRST_EN to emit the highest set line first instead of the lowest.
module line_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [15:0] req_lines,
   output logic        req_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_address,
   output logic        out_last
);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [15:0] pending_q, pending_d;
   logic [3:0]  sel_addr;
   logic        single_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   // The last match in the loop wins, so the scan direction sets the emission order.
   always_comb begin
      sel_addr = 4'd0;
`ifdef LINE_ENCODER_HIGH_FIRST_EN
      for (int i = 0; i < 16; i++) begin
         if (pending_q[i]) sel_addr = 4'(i);
      end
`else
      for (int i = 15; i >= 0; i--) begin
         if (pending_q[i]) sel_addr = 4'(i);
      end
`endif
   end

   assign single_bit = (pending_q != 16'd0) && ((pending_q & (pending_q - 16'd1)) == 16'd0);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         IDLE: begin
            // An all-zero vector is taken and dropped without leaving IDLE.
            if (req_valid && (req_lines != 16'd0)) begin
               pending_d = req_lines;
               state_d   = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               pending_d = pending_q & ~(16'd1 << sel_addr);
               if (single_bit) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = (state_q == IDLE);
      out_valid   = (state_q == EMIT);
      out_address = sel_addr;
      out_last    = (state_q == EMIT) && single_bit;
   end

endmodule

// File: tb/tb_line_encoder.sv
// tb/tb_line_encoder.sv - scoreboard bench for line_encoder with randomized vectors
module tb_line_encoder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [15:0] req_lines;
   logic        req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_address;
   logic        out_last;

   int total;
   int bad;
   logic [4:0] exp_q[$];

   logic       prev_stall;
   logic [3:0] prev_addr;
   logic       prev_last;

   line_encoder dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_lines(req_lines),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_address(out_address), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: list the set line indices, reorder if high-first, mark the final one.
   function automatic void model_push(input logic [15:0] v);
      logic [3:0] idx[$];
      for (int b = 0; b < 16; b++)
         if (v[b]) idx.push_back(4'(b));
`ifdef LINE_ENCODER_HIGH_FIRST_EN
      idx.reverse();
`endif
      foreach (idx[j]) exp_q.push_back({idx[j], 1'(j == idx.size() - 1)});
   endfunction

   task automatic send(input logic [15:0] v);
      int n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_lines = v;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 32'(req_ready), 32'd1);
      if (req_ready) model_push(v);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_lines = 16'($urandom);
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         req_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         req_lines = 16'($urandom);
         n++;
      end
      req_valid = 1'b0;
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      prev_stall = 1'b0;
      prev_addr  = 4'd0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_addr", 32'(out_address), 32'(prev_addr));
               chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", 32'(out_address), 32'hFFFF);
               end else begin
                  logic [4:0] e;
                  e = exp_q.pop_front();
                  chk("out_address", 32'(out_address), 32'(e[4:1]));
                  chk("out_last", 32'(out_last), 32'(e[0]));
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = out_address;
            prev_last  = out_last;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int hs;
      total     = 0;
      bad       = 0;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_lines = 16'd0;
      out_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_address", 32'(out_address), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      #20 rst = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);

      // 16'h8421 with a free-running consumer: four back-to-back addresses.
      send(16'h8421);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b2b_valid", 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      chk("b2b_ret_ready", 32'(req_ready), 32'd1);
      chk("b2b_ret_valid", 32'(out_valid), 32'd0);
      chk("b2b_drained", 32'(exp_q.size()), 32'd0);

      // All-zero vector is dropped; the next one is taken the following cycle.
      send(16'h0000);
      @(negedge clk);
      chk("zero_out_valid", 32'(out_valid), 32'd0);
      chk("zero_req_ready", 32'(req_ready), 32'd1);
      send(16'h0001);
      @(negedge clk);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_addr", 32'(out_address), 32'd0);
      chk("single_last", 32'(out_last), 32'd1);
      @(negedge clk);
      chk("single_ret_ready", 32'(req_ready), 32'd1);
      chk("single_ret_valid", 32'(out_valid), 32'd0);

      // Held consumer on 16'h0030.
      out_ready = 1'b0;
      send(16'h0030);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_addr", 32'(out_address), 32'(exp_q[0][4:1]));
         chk("hold_last", 32'(out_last), 32'd0);
      end
      drain(1'b0);

      // Reset in the middle of 16'hFFFF after two handshakes.
      out_ready = 1'b1;
      send(16'hFFFF);
      hs = 0;
      for (int n = 0; n < 20 && hs < 2; n++) begin
         @(negedge clk);
         if (out_valid && out_ready) hs++;
      end
      chk("ffff_handshakes", 32'(hs), 32'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_last", 32'(out_last), 32'd0);
      chk("mid_rst_addr", 32'(out_address), 32'd0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", 32'(out_valid), 32'd0);
      end
      send(16'h0002);
      @(negedge clk);
      chk("post_rst_addr", 32'(out_address), 32'd1);
      chk("post_rst_last", 32'(out_last), 32'd1);
      drain(1'b0);

      // Randomized vectors with a randomly stalling consumer and noise on the request side.
      for (int t = 0; t < 60; t++) begin
         logic [15:0] v;
         case ($urandom_range(0, 5))
            0:       v = 16'd0;
            1:       v = 16'd1 << $urandom_range(0, 15);
            default: v = 16'($urandom);
         endcase
         send(v);
         if (v == 16'd0) begin
            @(negedge clk);
            chk("rnd_zero_valid", 32'(out_valid), 32'd0);
         end
         drain(1'b1);
      end
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("final_valid", 32'(out_valid), 32'd0);
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
